// File: rtl/stream_mux.sv
// ============================================================================
// stream_mux : one-entry registered N:1 valid/ready stream mux with fixed or
//              round-robin channel selection and a transfer counter.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module stream_mux #(
  parameter int SEL = 3,
  parameter int N   = 2**SEL,
  parameter int W   = 8,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SEL-1:0] select,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SEL-1:0] out_chan,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  xfer_count
);

  logic [SEL-1:0] r_ptr;
  logic [W-1:0]   r_out_data;
  logic [SEL-1:0] r_out_chan;
  logic           r_out_valid;
  logic [CW-1:0]  r_xfer_count;

  logic           w_load_en;
  logic           w_rr_found;
  logic [SEL-1:0] w_rr_idx;
  logic [SEL-1:0] w_probe;
  logic [SEL-1:0] w_cand;
  logic           w_cand_ok;
  logic           w_grant;
  logic [W-1:0]   w_cand_data;

  assign w_load_en = !r_out_valid || out_ready;

  // Round-robin search: first valid channel starting at r_ptr, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_probe    = '0;
    for (int i = 0; i < N; i++) begin
      w_probe = r_ptr + SEL'(i);
      if (!w_rr_found && in_valid[w_probe]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_probe;
      end
    end
  end

  assign w_cand      = mode ? w_rr_idx : select;
  assign w_cand_ok   = mode ? w_rr_found : in_valid[select];
  assign w_grant     = !rst && w_load_en && w_cand_ok;
  assign w_cand_data = in_data[w_cand*W +: W];
  assign in_ready    = w_grant ? (N'(1) << w_cand) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_out_data   <= '0;
      r_out_chan   <= '0;
      r_out_valid  <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      if (w_grant) begin
        r_out_data  <= w_cand_data;
        r_out_chan  <= w_cand;
        r_out_valid <= 1'b1;
        if (mode) begin
          r_ptr <= w_cand + SEL'(1);
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && out_ready) begin
        r_xfer_count <= r_xfer_count + CW'(1);
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_chan   = r_out_chan;
  assign out_valid  = r_out_valid;
  assign xfer_count = r_xfer_count;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux.sv
// ============================================================================
// tb_stream_mux : scoreboard bench for stream_mux (SEL=2, N=4, W=8, CW=16).
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux;

  localparam int SEL = 2;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           mode = 1'b0;
  logic [SEL-1:0] select = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SEL-1:0] out_chan;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [CW-1:0]  xfer_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic           m_valid = 1'b0;
  logic [SEL-1:0] m_ptr = '0;
  logic [CW-1:0]  m_count = '0;
  logic [SEL+W-1:0] sb_q[$];

  stream_mux #(.SEL(SEL), .N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic set_data(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  // One clock cycle: predict grant, score any drain, advance the model.
  task automatic step();
    logic           load_en;
    logic           has;
    logic [SEL-1:0] g;
    logic [SEL-1:0] k;
    logic [N-1:0]   exp_ready;
    logic [SEL+W-1:0] exp_beat;
    #1;
    load_en = !m_valid || out_ready;
    has = 1'b0;
    g   = '0;
    if (!mode) begin
      if (in_valid[select]) begin
        has = 1'b1;
        g   = select;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        k = m_ptr + i[SEL-1:0];
        if (!has && in_valid[k]) begin
          has = 1'b1;
          g   = k;
        end
      end
    end
    exp_ready = (load_en && has) ? (4'b0001 << g) : 4'b0000;
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
    end
    if (m_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: drain with empty queue got %h expected none", out_data);
      end else begin
        exp_beat = sb_q.pop_front();
        checks++;
        if ({out_chan, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL beat: got chan %0d data %h expected chan %0d data %h",
                   out_chan, out_data, exp_beat[SEL+W-1:W], exp_beat[W-1:0]);
        end
      end
      m_count = m_count + 16'd1;
    end
    if (load_en && has) begin
      sb_q.push_back({g, in_data[g*W +: W]});
      m_valid = 1'b1;
      if (mode) m_ptr = g + 2'd1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, m_valid);
    end
    checks++;
    if (xfer_count !== m_count) begin
      errors++;
      $display("FAIL xfer_count: got %0d expected %0d", xfer_count, m_count);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = '0;
    m_count = '0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    mode      = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_chan, xfer_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v%b d%h c%0d n%0d expected all 0",
               out_valid, out_data, out_chan, xfer_count);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got v%b r%b expected 0 0000", out_valid, in_ready);
    end
    #2;
    rst = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fixed();
    mode = 1'b0; select = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'hA5); set_data(3, 8'h44);
    step();
    checks++;
    if (out_data !== 8'hA5 || out_chan !== 2'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fixed: got d%h c%0d v%b expected A5 2 1", out_data, out_chan, out_valid);
    end
    select = 2'd0; set_data(0, 8'h5A);
    step();
    in_valid = 4'b0000;
    step();
    step();
  endtask

  task automatic test_round_robin();
    test_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 8'hC0 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_chan !== 2'(i % N)) begin
        errors++;
        $display("FAIL rr_seq: got chan %0d expected %0d", out_chan, i % N);
      end
    end
    checks++;
    if (xfer_count !== 16'd4) begin
      errors++;
      $display("FAIL rr_count: got %0d expected 4", xfer_count);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    mode = 1'b0; select = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
    set_data(1, 8'h3C);
    step();
    set_data(1, 8'h99);
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_data !== 8'h3C || out_chan !== 2'd1 || in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL backpressure: got d%h c%0d r%b expected 3C 1 0000",
                 out_data, out_chan, in_ready);
      end
    end
    in_valid = 4'b0000; out_ready = 1'b1;
    step();
    checks++;
    if (xfer_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_count: got %0d expected 1", xfer_count);
    end
  endtask

  task automatic test_wrap_skip();
    test_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
    for (int i = 0; i < N; i++) set_data(i, 8'h70 + 8'(i));
    step();
    in_valid = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_grant: got %b expected 0010", in_ready);
    end
    step();
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_ptr: got %b expected 0100", in_ready);
    end
    step();
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    test_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (out_valid !== 1'b1 || xfer_count !== 16'd7) begin
      errors++;
      $display("FAIL mid_pre: got v%b n%0d expected 1 7", out_valid, xfer_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 || xfer_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_async: got v%b d%h c%0d n%0d expected 0 00 0 0",
               out_valid, out_data, out_chan, xfer_count);
    end
    #3;
    rst = 1'b0;
    model_reset();
    step();
    checks++;
    if (out_chan !== 2'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_first: got chan %0d v%b expected 0 1", out_chan, out_valid);
    end
  endtask

  task automatic test_counter_wrap();
    int budget;
    test_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    budget = 70000;
    while (m_count != 16'hFFFF && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (xfer_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_pre: got %0d expected 65535", xfer_count);
    end
    step();
    checks++;
    if (xfer_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", xfer_count);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SEL  3  select/channel-index width
  N    2**SEL  number of input channels (derived; not overridden)
  W    8  data width per channel
  CW   16  transfer-counter width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk        in   1      single clock; all state on rising edge
  rst        in   1      asynchronous, active-high reset
  mode       in   1      0 = fixed select, 1 = round-robin
  select     in   SEL    channel index used when mode=0
  in_data    in   N*W    channel k occupies bits [k*W +: W]
  in_valid   in   N      per-channel valid
  in_ready   out  N      per-channel ready; combinational
  out_data   out  W      registered output data
  out_chan   out  SEL    channel index of out_data
  out_valid  out  1      output register holds a beat
  out_ready  in   1      downstream accept
  xfer_count out  CW     count of completed output transfers

Function
REQ-003 The block SHALL be a one-entry registered N:1 stream mux with valid/ready on every input and on the output.
REQ-004 load_en SHALL equal (!out_valid) | out_ready.
REQ-005 Fixed mode (mode=0): the candidate SHALL be channel select, eligible only when in_valid[select]=1; other channels are never granted.
REQ-006 Round-robin mode (mode=1): the candidate SHALL be the first k with in_valid[k]=1, searching ptr, ptr+1, ..., wrapping from N-1 to 0.
REQ-007 Grant SHALL occur when load_en=1 and a candidate exists; in_ready SHALL be 1 only for the granted channel, all other bits 0.
REQ-008 On grant, the next edge SHALL load out_data=in_data[g], out_chan=g, out_valid=1; latency input-accept to out_valid is 1 cycle.
REQ-009 With out_valid=1 and out_ready=1 and no grant, out_valid SHALL clear on the next edge.
REQ-010 With out_valid=1 and out_ready=0, out_data and out_chan SHALL hold and all in_ready SHALL be 0.
REQ-011 Simultaneous output drain and grant SHALL replace the output beat in the same edge, sustaining 1 beat/cycle.
REQ-012 ptr SHALL update to (g+1) mod N on each grant in mode=1; in mode=0, ptr SHALL hold.
REQ-013 A change of mode or select SHALL only affect the next arbitration; a beat already in the output register SHALL be unaffected.
REQ-014 in_ready SHALL not depend on in_valid of non-candidate channels other than through the candidate search; no combinational path from out_ready to out_data.
REQ-015 xfer_count SHALL increment by 1 on each edge with out_valid & out_ready, wrapping from 2**CW-1 to 0.
REQ-016 select values are always in range since N=2**SEL; no out-of-range handling is required.

Reset
REQ-017 rst=1 SHALL immediately, without waiting for clk, force out_valid=0, out_data=0, out_chan=0, xfer_count=0, ptr=0.
REQ-018 During rst=1, in_ready SHALL be all 0.
REQ-019 A beat held in the output register when rst asserts SHALL be discarded and not counted.
REQ-020 After rst deasserts, the first round-robin search SHALL start at channel 0.

Verification (SEL=2, N=4, W=8, CW=16)
REQ-021 Fixed mode: mode=0, select=2, in_valid=4'b1111, in_data ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_chan=2, out_valid=1.
REQ-022 Round-robin fairness: mode=1, in_valid=4'b1111 constant, out_ready=1 after reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles, xfer_count=4 after 5 loads/4 drains.
REQ-023 Backpressure: output holds 0x3C from ch1, out_ready=0 for 5 cycles -> out_data=0x3C, out_chan=1 stable, in_ready=0; out_ready=1 -> xfer_count increments by exactly 1.
REQ-024 Wrap/skip: mode=1, ptr=3, in_valid=4'b0010 -> grant ch1; next ptr=2.
REQ-025 Reset mid-operation: out_valid=1, xfer_count=7, rst pulsed between clock edges -> outputs 0 immediately, xfer_count=0, next round-robin grant from ch0.
REQ-026 Counter wrap: preload by 65535 transfers -> next transfer gives xfer_count=0.
